axi_lite_to_mem_bridge: RTL
===========================

# axi_lite_to_mem_bridge

AXI4-Lite slave that converts each incoming read or write into a single request/grant/response memory transaction, with one transaction outstanding at a time. It is the counterpart of the existing memory-to-AXI-Lite master bridge. It lets the PS, or any AXI-Lite master on the FPGA block design, reach X-HEEP-side memory-protocol slaves such as the DRAM controller port or peripheral banks.

## Interface
- MemAddrWidth, 32: memory address width.
- AxiAddrWidth, 32: AXI address width; must be ≥ MemAddrWidth.
- DataWidth, 32: data width of both sides; strobe width is DataWidth/8.

Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- S_AXI_AWADDR/AWPROT/AWVALID  in  AxiAddrWidth/3/1; S_AXI_AWREADY  out  1
- S_AXI_WDATA/WSTRB/WVALID  in  DataWidth/DataWidth/8/1; S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1
- S_AXI_ARADDR/ARPROT/ARVALID  in  AxiAddrWidth/3/1; S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  DataWidth; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1
- mem_req_o  out  1  request valid
- mem_addr_o  out  MemAddrWidth  request address
- mem_we_o  out  1  write enable
- mem_wdata_o  out  DataWidth  write data
- mem_be_o  out  DataWidth/8  byte enables
- mem_gnt_i  in  1  grant
- mem_rsp_valid_i  in  1  response valid
- mem_rsp_rdata_i  in  DataWidth  read data
- mem_rsp_error_i  in  1  response error

## Operation
- FSM states: IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- **IDLE, write accept**
  - A write is eligible only when AWVALID and WVALID are both high.
  - AWREADY and WREADY assert together in that cycle, combinationally from the valids and arbitration.
  - The module never accepts AW without W, or W without AW.
- **IDLE, read accept:** a read is eligible when ARVALID is high; ARREADY asserts in that cycle.
- **Arbitration:** when a write and a read are both eligible, a last_was_write flag picks the other kind, and the flag updates on every accept. Reset value of the flag is 1, so reads win first.
- **On accept:** register address (low MemAddrWidth bits of AxADDR), WDATA, and WSTRB. Go to WR_REQ or RD_REQ. AxPROT is ignored.
- **WR_REQ / RD_REQ**
  - Drive mem_req_o=1 with stable registered address, data, be and we until mem_gnt_i.
  - mem_we_o=1 for writes and 0 for reads; mem_be_o is all ones for reads.
  - A write with WSTRB=0 is still issued, with be=0.
- **On grant:** drop mem_req_o in the next cycle and go to *_WAIT.
- ***_WAIT:** wait for mem_rsp_valid_i.
  - rsp_valid asserted in the grant cycle itself is ignored, because the memory protocol guarantees a response no earlier than the cycle after grant.
  - On response, capture rdata and error, then go to *_RESP.
- **WR_RESP:** BVALID=1, BRESP = error ? SLVERR (2'b10) : OKAY (2'b00). Hold until BREADY, then go to IDLE.
- **RD_RESP:** RVALID=1, RDATA = captured data, RRESP as for writes. RDATA is passed through even on error. Hold until RREADY, then go to IDLE.
- **Boundary behaviour**
  - No accept is possible outside IDLE: all readies are 0.
  - B/R payloads are stable while valid.
  - A response that arrives while in *_REQ is a protocol violation and is not handled.

## Timing
- **Reset values:** all readies, BVALID, RVALID and mem_req_o are 0; all data, address, be and resp outputs are 0; mem_we_o is 0; state is IDLE.
- Reset asserted mid-transaction aborts immediately to IDLE. It does not wait for an outstanding memory response, and a late response is ignored.
- **Minimum latency:** accept in cycle N; mem_req_o in N+1 (grant in the same cycle); response in N+2; BVALID/RVALID in N+3; earliest next accept in N+4.
- **Back-to-back transactions:** one per 4 cycles minimum with zero-wait memory and an always-ready master.

## Structure
- Shared package axi_lite_mem_pkg holds:
  - constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the state enum bridge_state_e.
- Single module; no sub-module needed. The datapath is one holding register set shared by reads and writes.

## Test plan
- **Single write:** AWADDR=0x1000_0004, WDATA=0xDEADBEEF, WSTRB=0xF, with zero-wait memory. Expect mem_req_o in cycle N+1 with addr 0x1000_0004, we=1, be=0xF, and BVALID with BRESP=00 in cycle N+3.
- **Single read:** ARADDR=0x20; memory returns 0x1234_5678 after grant stalled 3 cycles and rsp 2 cycles later. Expect mem_req_o held 4 cycles, then RVALID with RDATA=0x12345678 and RRESP=00.
- **Error:** mem_rsp_error_i=1 on a write and then on a read. Expect BRESP=10 and RRESP=10.
- **Simultaneous valids:** AW/W and AR all valid after reset. Expect the read accepted first, then the write; with both persistently valid, strict alternation.
- **Backpressure:** BREADY held low 5 cycles. Expect BVALID/BRESP stable, no AWREADY/ARREADY during that time, and IDLE resumed after BREADY. AWVALID alone, without WVALID, must never be accepted.
- **Async reset in RD_WAIT:** all outputs go to 0 at once. A late mem_rsp_valid_i produces no RVALID, and a following read completes normally.

Source files
------------

// File: rtl/axi_lite_mem_pkg.sv
// Shared types and constants for the AXI4-Lite to memory-protocol bridge.
package axi_lite_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    WR_RESP,
    RD_REQ,
    RD_WAIT,
    RD_RESP
  } bridge_state_e;

endpackage

// File: rtl/axi_lite_to_mem_bridge.sv
// AXI4-Lite slave issuing one request/grant/response memory transaction per AXI
// read or write, with a single transaction in flight.
module axi_lite_to_mem_bridge
  import axi_lite_mem_pkg::*;
#(
  parameter int MemAddrWidth = 32,
  parameter int AxiAddrWidth = 32,
  parameter int DataWidth    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [AxiAddrWidth-1:0] S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DataWidth-1:0]    S_AXI_WDATA,
  input  logic [DataWidth/8-1:0]  S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [AxiAddrWidth-1:0] S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DataWidth-1:0]    S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic                    mem_req_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic                    mem_we_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [DataWidth/8-1:0]  mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rsp_valid_i,
  input  logic [DataWidth-1:0]    mem_rsp_rdata_i,
  input  logic                    mem_rsp_error_i
);

  bridge_state_e state;
  logic          last_was_write;
  logic          wr_elig;
  logic          rd_elig;
  logic          take_wr;
  logic          take_rd;
  logic          unused_ok;

  // Protection bits are not forwarded; the upper AXI address bits are dropped.
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // On a write/read collision, serve the kind that did not go last.
  always_comb begin
    wr_elig = S_AXI_AWVALID && S_AXI_WVALID;
    rd_elig = S_AXI_ARVALID;
    take_wr = 1'b0;
    take_rd = 1'b0;
    if (state == IDLE && !rst_i) begin
      if (wr_elig && rd_elig) begin
        take_wr = !last_was_write;
        take_rd = last_was_write;
      end else begin
        take_wr = wr_elig;
        take_rd = rd_elig;
      end
    end
  end

  assign S_AXI_AWREADY = take_wr;
  assign S_AXI_WREADY  = take_wr;
  assign S_AXI_ARREADY = take_rd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      last_was_write <= 1'b1;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      mem_be_o       <= '0;
      S_AXI_BVALID   <= 1'b0;
      S_AXI_BRESP    <= RESP_OKAY;
      S_AXI_RVALID   <= 1'b0;
      S_AXI_RDATA    <= '0;
      S_AXI_RRESP    <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (take_rd) begin
            state          <= RD_REQ;
            last_was_write <= 1'b0;
            mem_req_o      <= 1'b1;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= S_AXI_ARADDR[MemAddrWidth-1:0];
            mem_be_o       <= '1;
          end else if (take_wr) begin
            state          <= WR_REQ;
            last_was_write <= 1'b1;
            mem_req_o      <= 1'b1;
            mem_we_o       <= 1'b1;
            mem_addr_o     <= S_AXI_AWADDR[MemAddrWidth-1:0];
            mem_wdata_o    <= S_AXI_WDATA;
            mem_be_o       <= S_AXI_WSTRB;
          end
        end
        WR_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (mem_rsp_valid_i) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= mem_rsp_error_i ? RESP_SLVERR : RESP_OKAY;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            state        <= IDLE;
          end
        end
        RD_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Read data is returned even when the memory flags an error.
          if (mem_rsp_valid_i) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= mem_rsp_rdata_i;
            S_AXI_RRESP  <= mem_rsp_error_i ? RESP_SLVERR : RESP_OKAY;
            state        <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
